decode_stage: RTL and testbench
===============================

Name: decode_stage

Overview:
- Pipeline stage directly downstream of instruction fetch.
- Registers the fetched instruction word, PC and branch-prediction bit, and decodes them into register specifiers, a sign-extended 64-bit immediate and execute/memory control.
- Detects load-use hazards against the instruction it is currently presenting to execute. On a hazard it stalls fetch for one cycle and injects a bubble.

Parameters:
- NOP_INSTR, 64'h0000_0000_0000_0013, instruction word fetch substitutes on flush; decoded as a write to x0 with no effect.
- LOAD_USE_STALL, 1, 1 enables load-use interlock; 0 ties stall_out low (forwarding network handles it).

Ports:
- clk  in  1  clock
- reset  in  1  synchronous active-high reset
- stall_in  in  1  downstream stall; hold all outputs
- flush_in  in  1  squash; next output is a bubble
- pc_in  in  64  PC of instr_in (fetch pc_out)
- instr_in  in  64  instruction word (fetch instr_out); RV encoding in [31:0]
- branch_predicted_taken_in  in  1  fetch prediction bit
- stall_out  out  1  combinational load-use stall request to fetch
- valid_out  out  1  outputs hold a real instruction
- pc_out  out  64  registered PC
- branch_predicted_taken_out  out  1  registered prediction
- rs1_out, rs2_out, rd_out  out  5 each  register specifiers
- rs1_read_out, rs2_read_out  out  1 each  operand actually used
- imm_out  out  64  sign-extended immediate
- alu_op_out  out  4  0 ADD, 1 SUB, 2 SLL, 3 SLT, 4 SLTU, 5 XOR, 6 SRL, 7 SRA, 8 OR, 9 AND, 10 PASS_B
- alu_src_pc_out, alu_src_imm_out  out  1 each  operand A = PC, operand B = imm
- word_out  out  1  32-bit (W) op, result sign-extended downstream
- mem_read_out, mem_write_out  out  1 each
- mem_width_out  out  3  funct3 of load/store
- reg_write_out  out  1  writes rd; forced 0 when rd == 0
- branch_out, jump_out  out  1 each  conditional branch; JAL/JALR
- illegal_out  out  1  see Optional Feature

Behaviour:
- Field extraction: opcode [6:0], rd [11:7], funct3 [14:12], rs1 [19:15], rs2 [24:20], funct7 [31:25].
- Immediates (I/S/B/U/J) are built per the RV base formats and sign-extended from bit 31 to 64 bits. U-type is imm[31:12]<<12 sign-extended.
- Supported opcodes:
  - LUI: PASS_B, imm.
  - AUIPC: ADD, pc, imm.
  - JAL / JALR: jump_out; ADD pc+4 is computed in execute.
  - BRANCH: branch_out, rs1/rs2 read.
  - LOAD and STORE.
  - OP-IMM, OP, OP-IMM-32, OP-32.
  - W ops set word_out.
  - SUB/SRA are selected by funct7[5].
- Latency: 1 cycle from the instr_in sample edge to registered outputs.
- Update priority at each posedge, highest first:
  1. reset: valid_out = 0, all control/specifier/imm/pc outputs = 0.
  2. flush_in: bubble (valid_out = 0, all control = 0; pc/imm don't-care but driven 0).
  3. stall_in: every output register holds.
  4. hazard: bubble inserted; instr_in is not consumed (fetch is stalled by stall_out).
  5. Otherwise: decode instr_in and set valid_out = 1.
- hazard condition, when LOAD_USE_STALL = 1, all of:
  - valid_out & mem_read_out & (rd_out != 0), and
  - either (rs1_read_now & rs1_now == rd_out) or (rs2_read_now & rs2_now == rd_out).
  - *_now terms are decoded combinationally from instr_in.
- stall_out = hazard & ~flush_in & ~reset. It is asserted for exactly one cycle per hazard, because the bubble clears valid_out.
- Simultaneous events:
  - flush_in + hazard: flush wins; stall_out low.
  - stall_in + hazard: outputs hold; stall_out stays high until stall_in drops.
- Reset mid-stall: stall_out is low in the reset cycle; the first post-reset output is a bubble.
- Instruction equal to NOP_INSTR: valid, reg_write_out = 0.

Optional Feature:
- Macro: DECODE_ILLEGAL_TRAP_EN.
- Defined: illegal_out = 1 with valid_out = 1 when any of the following holds; all other control outputs are 0 in that case:
  - instr_in[63:32] != 0;
  - instr_in[1:0] != 2'b11;
  - opcode is unsupported;
  - OP/OP-32 funct7 is not 0 or 0x20.
- Not defined: illegal_out is tied 0; unsupported encodings decode as a valid bubble-equivalent (all control 0, valid_out = 1).

Test Plan:
- Reset then ADDI x5,x0,7 (0x00700293) at pc 0x100 -> next cycle valid_out=1, rd_out=5, imm_out=7, alu_op_out=0, alu_src_imm_out=1, reg_write_out=1, pc_out=0x100.
- LD x6,0(x5) followed by ADD x7,x6,x1 -> stall_out=1 for one cycle; bubble (valid_out=0); then ADD decoded with rs1_out=6. With LOAD_USE_STALL=0, no stall.
- LD x0,0(x5) followed by ADD x7,x0,x1 -> no stall; load reg_write_out=0.
- BEQ with negative offset -8 (0xFE000CE3) -> branch_out=1, imm_out=64'hFFFF_FFFF_FFFF_FFF8; branch_predicted_taken_out matches input.
- Hazard cycle with flush_in=1 -> stall_out=0, next valid_out=0. Then stall_in held 3 cycles -> all outputs unchanged.
- With DECODE_ILLEGAL_TRAP_EN defined, instr_in = 64'h1_0000_0013 -> illegal_out=1, valid_out=1, reg_write_out=0.

Source files
------------

// File: rtl/decode_stage.sv
// Decode stage: registers fetch output, decodes RV64 fields/immediates/control, load-use interlock.
// Optional build macro DECODE_ILLEGAL_TRAP_EN enables illegal-instruction flagging on illegal_out.
module decode_stage #(
  parameter logic [63:0] NOP_INSTR      = 64'h0000_0000_0000_0013,
  parameter bit          LOAD_USE_STALL = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall_in,
  input  logic        flush_in,
  input  logic [63:0] pc_in,
  input  logic [63:0] instr_in,
  input  logic        branch_predicted_taken_in,
  output logic        stall_out,
  output logic        valid_out,
  output logic [63:0] pc_out,
  output logic        branch_predicted_taken_out,
  output logic [4:0]  rs1_out,
  output logic [4:0]  rs2_out,
  output logic [4:0]  rd_out,
  output logic        rs1_read_out,
  output logic        rs2_read_out,
  output logic [63:0] imm_out,
  output logic [3:0]  alu_op_out,
  output logic        alu_src_pc_out,
  output logic        alu_src_imm_out,
  output logic        word_out,
  output logic        mem_read_out,
  output logic        mem_write_out,
  output logic [2:0]  mem_width_out,
  output logic        reg_write_out,
  output logic        branch_out,
  output logic        jump_out,
  output logic        illegal_out
);

  localparam int unsigned XLEN = 64;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OPIMM32 = 7'b0011011;
  localparam logic [6:0] OPC_OP32   = 7'b0111011;

  localparam logic [3:0] ALU_ADD    = 4'd0;
  localparam logic [3:0] ALU_SUB    = 4'd1;
  localparam logic [3:0] ALU_SLL    = 4'd2;
  localparam logic [3:0] ALU_SLT    = 4'd3;
  localparam logic [3:0] ALU_SLTU   = 4'd4;
  localparam logic [3:0] ALU_XOR    = 4'd5;
  localparam logic [3:0] ALU_SRL    = 4'd6;
  localparam logic [3:0] ALU_SRA    = 4'd7;
  localparam logic [3:0] ALU_OR     = 4'd8;
  localparam logic [3:0] ALU_AND    = 4'd9;
  localparam logic [3:0] ALU_PASS_B = 4'd10;

  typedef struct packed {
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [4:0]      rd;
    logic            rs1_read;
    logic            rs2_read;
    logic [XLEN-1:0] imm;
    logic [3:0]      alu_op;
    logic            alu_src_pc;
    logic            alu_src_imm;
    logic            word;
    logic            mem_read;
    logic            mem_write;
    logic [2:0]      mem_width;
    logic            reg_write;
    logic            branch;
    logic            jump;
    logic            illegal;
  } dec_t;

  // funct3 -> ALU op; alt (instr[30]) picks SUB only for register ops, SRA for both
  function automatic logic [3:0] alu_from_f3(input logic [2:0] f3, input logic alt,
                                             input logic reg_op);
    logic [3:0] op;
    case (f3)
      3'b000:  op = (alt && reg_op) ? ALU_SUB : ALU_ADD;
      3'b001:  op = ALU_SLL;
      3'b010:  op = ALU_SLT;
      3'b011:  op = ALU_SLTU;
      3'b100:  op = ALU_XOR;
      3'b101:  op = alt ? ALU_SRA : ALU_SRL;
      3'b110:  op = ALU_OR;
      default: op = ALU_AND;
    endcase
    return op;
  endfunction

  dec_t            dec_q, dec_d, dec_now;
  logic            valid_q, valid_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic            bpt_q, bpt_d;
  logic            hazard_c;

  logic [6:0]      opcode;
  logic [4:0]      rd_f, rs1_f, rs2_f;
  logic [2:0]      funct3;
  logic [6:0]      funct7;
  logic [XLEN-1:0] imm_i, imm_s, imm_b, imm_u, imm_j;
  logic            supported;
  logic            is_nop;

  assign opcode = instr_in[6:0];
  assign rd_f   = instr_in[11:7];
  assign funct3 = instr_in[14:12];
  assign rs1_f  = instr_in[19:15];
  assign rs2_f  = instr_in[24:20];
  assign funct7 = instr_in[31:25];
  assign is_nop = (instr_in == NOP_INSTR);

  assign imm_i = {{52{instr_in[31]}}, instr_in[31:20]};
  assign imm_s = {{52{instr_in[31]}}, instr_in[31:25], instr_in[11:7]};
  assign imm_b = {{51{instr_in[31]}}, instr_in[31], instr_in[7], instr_in[30:25],
                  instr_in[11:8], 1'b0};
  assign imm_u = {{32{instr_in[31]}}, instr_in[31:12], 12'b0};
  assign imm_j = {{43{instr_in[31]}}, instr_in[31], instr_in[19:12], instr_in[20],
                  instr_in[30:21], 1'b0};

  // Combinational decode of the instruction currently offered by fetch
  always_comb begin
    dec_now   = '0;
    supported = 1'b1;
    case (opcode)
      OPC_LUI: begin
        dec_now.rd          = rd_f;
        dec_now.imm         = imm_u;
        dec_now.alu_op      = ALU_PASS_B;
        dec_now.alu_src_imm = 1'b1;
        dec_now.reg_write   = 1'b1;
      end
      OPC_AUIPC: begin
        dec_now.rd          = rd_f;
        dec_now.imm         = imm_u;
        dec_now.alu_op      = ALU_ADD;
        dec_now.alu_src_pc  = 1'b1;
        dec_now.alu_src_imm = 1'b1;
        dec_now.reg_write   = 1'b1;
      end
      OPC_JAL: begin
        dec_now.rd         = rd_f;
        dec_now.imm        = imm_j;
        dec_now.alu_op     = ALU_ADD;
        dec_now.alu_src_pc = 1'b1;
        dec_now.jump       = 1'b1;
        dec_now.reg_write  = 1'b1;
      end
      OPC_JALR: begin
        dec_now.rd         = rd_f;
        dec_now.rs1        = rs1_f;
        dec_now.rs1_read   = 1'b1;
        dec_now.imm        = imm_i;
        dec_now.alu_op     = ALU_ADD;
        dec_now.alu_src_pc = 1'b1;
        dec_now.jump       = 1'b1;
        dec_now.reg_write  = 1'b1;
      end
      OPC_BRANCH: begin
        dec_now.rs1      = rs1_f;
        dec_now.rs2      = rs2_f;
        dec_now.rs1_read = 1'b1;
        dec_now.rs2_read = 1'b1;
        dec_now.imm      = imm_b;
        dec_now.alu_op   = ALU_SUB;
        dec_now.branch   = 1'b1;
      end
      OPC_LOAD: begin
        dec_now.rd          = rd_f;
        dec_now.rs1         = rs1_f;
        dec_now.rs1_read    = 1'b1;
        dec_now.imm         = imm_i;
        dec_now.alu_op      = ALU_ADD;
        dec_now.alu_src_imm = 1'b1;
        dec_now.mem_read    = 1'b1;
        dec_now.mem_width   = funct3;
        dec_now.reg_write   = 1'b1;
      end
      OPC_STORE: begin
        dec_now.rs1         = rs1_f;
        dec_now.rs2         = rs2_f;
        dec_now.rs1_read    = 1'b1;
        dec_now.rs2_read    = 1'b1;
        dec_now.imm         = imm_s;
        dec_now.alu_op      = ALU_ADD;
        dec_now.alu_src_imm = 1'b1;
        dec_now.mem_write   = 1'b1;
        dec_now.mem_width   = funct3;
      end
      OPC_OPIMM, OPC_OPIMM32: begin
        dec_now.rd          = rd_f;
        dec_now.rs1         = rs1_f;
        dec_now.rs1_read    = 1'b1;
        dec_now.imm         = imm_i;
        dec_now.alu_op      = alu_from_f3(funct3, funct7[5], 1'b0);
        dec_now.alu_src_imm = 1'b1;
        dec_now.word        = (opcode == OPC_OPIMM32);
        dec_now.reg_write   = 1'b1;
      end
      OPC_OP, OPC_OP32: begin
        dec_now.rd        = rd_f;
        dec_now.rs1       = rs1_f;
        dec_now.rs2       = rs2_f;
        dec_now.rs1_read  = 1'b1;
        dec_now.rs2_read  = 1'b1;
        dec_now.alu_op    = alu_from_f3(funct3, funct7[5], 1'b1);
        dec_now.word      = (opcode == OPC_OP32);
        dec_now.reg_write = 1'b1;
      end
      default: supported = 1'b0;
    endcase

    if (dec_now.rd == 5'd0 || is_nop) begin
      dec_now.reg_write = 1'b0;
    end

`ifdef DECODE_ILLEGAL_TRAP_EN
    if (!supported || (instr_in[63:32] != 32'd0) || (instr_in[1:0] != 2'b11) ||
        (((opcode == OPC_OP) || (opcode == OPC_OP32)) &&
         (funct7 != 7'h00) && (funct7 != 7'h20))) begin
      dec_now         = '0;
      dec_now.illegal = 1'b1;
    end
`else
    if (!supported) begin
      dec_now = '0;
    end
`endif
  end

  // Load in execute slot whose rd is consumed by the instruction waiting in fetch
  always_comb begin
    hazard_c = 1'b0;
    if (LOAD_USE_STALL && valid_q && dec_q.mem_read && (dec_q.rd != 5'd0)) begin
      hazard_c = (dec_now.rs1_read && (dec_now.rs1 == dec_q.rd)) ||
                 (dec_now.rs2_read && (dec_now.rs2 == dec_q.rd));
    end
  end

  assign stall_out = hazard_c & ~flush_in & ~reset;

  // Next-state: flush > stall > hazard bubble > decode
  always_comb begin
    valid_d = valid_q;
    dec_d   = dec_q;
    pc_d    = pc_q;
    bpt_d   = bpt_q;
    if (flush_in || (!stall_in && hazard_c)) begin
      valid_d = 1'b0;
      dec_d   = '0;
      pc_d    = '0;
      bpt_d   = 1'b0;
    end else if (!stall_in) begin
      valid_d = 1'b1;
      dec_d   = dec_now;
      pc_d    = pc_in;
      bpt_d   = branch_predicted_taken_in;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q <= 1'b0;
      dec_q   <= '0;
      pc_q    <= '0;
      bpt_q   <= 1'b0;
    end else begin
      valid_q <= valid_d;
      dec_q   <= dec_d;
      pc_q    <= pc_d;
      bpt_q   <= bpt_d;
    end
  end

  assign valid_out                  = valid_q;
  assign pc_out                     = pc_q;
  assign branch_predicted_taken_out = bpt_q;
  assign rs1_out                    = dec_q.rs1;
  assign rs2_out                    = dec_q.rs2;
  assign rd_out                     = dec_q.rd;
  assign rs1_read_out               = dec_q.rs1_read;
  assign rs2_read_out               = dec_q.rs2_read;
  assign imm_out                    = dec_q.imm;
  assign alu_op_out                 = dec_q.alu_op;
  assign alu_src_pc_out             = dec_q.alu_src_pc;
  assign alu_src_imm_out            = dec_q.alu_src_imm;
  assign word_out                   = dec_q.word;
  assign mem_read_out               = dec_q.mem_read;
  assign mem_write_out              = dec_q.mem_write;
  assign mem_width_out              = dec_q.mem_width;
  assign reg_write_out              = dec_q.reg_write;
  assign branch_out                 = dec_q.branch;
  assign jump_out                   = dec_q.jump;
  assign illegal_out                = dec_q.illegal;

endmodule

// File: tb/tb_decode_stage.sv
// Directed self-checking bench for decode_stage: decode fields, load-use interlock, flush/stall/reset priority.
module tb_decode_stage;

  localparam logic [63:0] I_ADDI  = 64'h0000_0000_0070_0293; // addi x5,x0,7
  localparam logic [63:0] I_LD6   = 64'h0000_0000_0002_B303; // ld x6,0(x5)
  localparam logic [63:0] I_ADD76 = 64'h0000_0000_0013_03B3; // add x7,x6,x1
  localparam logic [63:0] I_LD0   = 64'h0000_0000_0002_B003; // ld x0,0(x5)
  localparam logic [63:0] I_ADD70 = 64'h0000_0000_0010_03B3; // add x7,x0,x1
  localparam logic [63:0] I_BEQ   = 64'h0000_0000_FE00_0CE3; // beq x0,x0,-8
  localparam logic [63:0] I_SUB   = 64'h0000_0000_4020_81B3; // sub x3,x1,x2
  localparam logic [63:0] I_LUI   = 64'h0000_0000_8000_0537; // lui x10,0x80000
  localparam logic [63:0] I_ADDIW = 64'h0000_0000_FFF2_021B; // addiw x4,x4,-1
  localparam logic [63:0] I_SD    = 64'h0000_0000_0020_B423; // sd x2,8(x1)
  localparam logic [63:0] I_NOP   = 64'h0000_0000_0000_0013;

  logic        clk = 1'b0;
  logic        reset, stall_in, flush_in, bpt_in;
  logic [63:0] pc_in, instr_in;
  logic        stall_out, valid_out, bpt_out, rs1_read_out, rs2_read_out;
  logic [63:0] pc_out, imm_out;
  logic [4:0]  rs1_out, rs2_out, rd_out;
  logic [3:0]  alu_op_out;
  logic        alu_src_pc_out, alu_src_imm_out, word_out, mem_read_out, mem_write_out;
  logic [2:0]  mem_width_out;
  logic        reg_write_out, branch_out, jump_out, illegal_out;

  int n_cmp = 0;
  int n_err = 0;

  decode_stage dut (
    .clk(clk), .reset(reset), .stall_in(stall_in), .flush_in(flush_in),
    .pc_in(pc_in), .instr_in(instr_in), .branch_predicted_taken_in(bpt_in),
    .stall_out(stall_out), .valid_out(valid_out), .pc_out(pc_out),
    .branch_predicted_taken_out(bpt_out), .rs1_out(rs1_out), .rs2_out(rs2_out),
    .rd_out(rd_out), .rs1_read_out(rs1_read_out), .rs2_read_out(rs2_read_out),
    .imm_out(imm_out), .alu_op_out(alu_op_out), .alu_src_pc_out(alu_src_pc_out),
    .alu_src_imm_out(alu_src_imm_out), .word_out(word_out), .mem_read_out(mem_read_out),
    .mem_write_out(mem_write_out), .mem_width_out(mem_width_out),
    .reg_write_out(reg_write_out), .branch_out(branch_out), .jump_out(jump_out),
    .illegal_out(illegal_out)
  );

  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; stall_in = 1'b0; flush_in = 1'b0; bpt_in = 1'b0;
    pc_in = 64'h0; instr_in = I_ADDI;
    cyc(); cyc();
    n_cmp++; if (valid_out !== 1'b0) begin n_err++; $display("FAIL reset_valid got %0h exp 0", valid_out); end
    n_cmp++; if (pc_out !== 64'h0) begin n_err++; $display("FAIL reset_pc got %0h exp 0", pc_out); end
    n_cmp++; if (reg_write_out !== 1'b0) begin n_err++; $display("FAIL reset_regwr got %0h exp 0", reg_write_out); end
    n_cmp++; if (imm_out !== 64'h0) begin n_err++; $display("FAIL reset_imm got %0h exp 0", imm_out); end
    n_cmp++; if (stall_out !== 1'b0) begin n_err++; $display("FAIL reset_stall got %0h exp 0", stall_out); end
  endtask

  task automatic test_addi();
    reset = 1'b0; instr_in = I_ADDI; pc_in = 64'h100;
    cyc();
    n_cmp++; if (valid_out !== 1'b1) begin n_err++; $display("FAIL addi_valid got %0h exp 1", valid_out); end
    n_cmp++; if (rd_out !== 5'd5) begin n_err++; $display("FAIL addi_rd got %0d exp 5", rd_out); end
    n_cmp++; if (imm_out !== 64'd7) begin n_err++; $display("FAIL addi_imm got %0h exp 7", imm_out); end
    n_cmp++; if (alu_op_out !== 4'd0) begin n_err++; $display("FAIL addi_alu got %0d exp 0", alu_op_out); end
    n_cmp++; if (alu_src_imm_out !== 1'b1) begin n_err++; $display("FAIL addi_srcimm got %0h exp 1", alu_src_imm_out); end
    n_cmp++; if (reg_write_out !== 1'b1) begin n_err++; $display("FAIL addi_regwr got %0h exp 1", reg_write_out); end
    n_cmp++; if (pc_out !== 64'h100) begin n_err++; $display("FAIL addi_pc got %0h exp 100", pc_out); end
  endtask

  task automatic test_load_use();
    instr_in = I_LD6; pc_in = 64'h104;
    cyc();
    n_cmp++; if (mem_read_out !== 1'b1 || rd_out !== 5'd6 || mem_width_out !== 3'd3) begin
      n_err++; $display("FAIL ld_decode got mr=%0h rd=%0d w=%0d exp 1 6 3", mem_read_out, rd_out, mem_width_out); end
    instr_in = I_ADD76; pc_in = 64'h108;
    #1;
    n_cmp++; if (stall_out !== 1'b1) begin n_err++; $display("FAIL lu_stall got %0h exp 1", stall_out); end
    cyc();
    n_cmp++; if (valid_out !== 1'b0) begin n_err++; $display("FAIL lu_bubble got %0h exp 0", valid_out); end
    n_cmp++; if (stall_out !== 1'b0) begin n_err++; $display("FAIL lu_stall_once got %0h exp 0", stall_out); end
    cyc();
    n_cmp++; if (valid_out !== 1'b1 || rs1_out !== 5'd6 || rs2_out !== 5'd1 || rd_out !== 5'd7) begin
      n_err++; $display("FAIL lu_add got v=%0h rs1=%0d rs2=%0d rd=%0d exp 1 6 1 7", valid_out, rs1_out, rs2_out, rd_out); end
    n_cmp++; if (pc_out !== 64'h108 || alu_op_out !== 4'd0 || alu_src_imm_out !== 1'b0) begin
      n_err++; $display("FAIL lu_add_ctl got pc=%0h alu=%0d si=%0h exp 108 0 0", pc_out, alu_op_out, alu_src_imm_out); end
  endtask

  task automatic test_x0_load();
    instr_in = I_LD0; pc_in = 64'h10C;
    cyc();
    n_cmp++; if (reg_write_out !== 1'b0 || mem_read_out !== 1'b1) begin
      n_err++; $display("FAIL ldx0 got rw=%0h mr=%0h exp 0 1", reg_write_out, mem_read_out); end
    instr_in = I_ADD70; pc_in = 64'h110;
    #1;
    n_cmp++; if (stall_out !== 1'b0) begin n_err++; $display("FAIL ldx0_stall got %0h exp 0", stall_out); end
    cyc();
    n_cmp++; if (valid_out !== 1'b1 || rd_out !== 5'd7 || pc_out !== 64'h110) begin
      n_err++; $display("FAIL ldx0_add got v=%0h rd=%0d pc=%0h exp 1 7 110", valid_out, rd_out, pc_out); end
  endtask

  task automatic test_branch();
    instr_in = I_BEQ; pc_in = 64'h200; bpt_in = 1'b1;
    cyc();
    n_cmp++; if (branch_out !== 1'b1) begin n_err++; $display("FAIL beq_branch got %0h exp 1", branch_out); end
    n_cmp++; if (imm_out !== 64'hFFFF_FFFF_FFFF_FFF8) begin n_err++; $display("FAIL beq_imm got %0h exp fffffffffffffff8", imm_out); end
    n_cmp++; if (bpt_out !== 1'b1) begin n_err++; $display("FAIL beq_bpt got %0h exp 1", bpt_out); end
    n_cmp++; if (reg_write_out !== 1'b0 || rs1_read_out !== 1'b1 || rs2_read_out !== 1'b1) begin
      n_err++; $display("FAIL beq_ctl got rw=%0h r1=%0h r2=%0h exp 0 1 1", reg_write_out, rs1_read_out, rs2_read_out); end
    bpt_in = 1'b0;
  endtask

  task automatic test_flush_stall();
    instr_in = I_LD6; pc_in = 64'h300;
    cyc();
    instr_in = I_ADD76; pc_in = 64'h304; flush_in = 1'b1;
    #1;
    n_cmp++; if (stall_out !== 1'b0) begin n_err++; $display("FAIL flush_stall got %0h exp 0", stall_out); end
    cyc();
    flush_in = 1'b0;
    n_cmp++; if (valid_out !== 1'b0 || mem_read_out !== 1'b0) begin
      n_err++; $display("FAIL flush_bubble got v=%0h mr=%0h exp 0 0", valid_out, mem_read_out); end
    instr_in = I_LD6; pc_in = 64'h308;
    cyc();
    stall_in = 1'b1; instr_in = I_ADD76; pc_in = 64'h30C;
    for (int i = 0; i < 3; i++) begin
      cyc();
      n_cmp++; if (valid_out !== 1'b1 || mem_read_out !== 1'b1 || rd_out !== 5'd6 || pc_out !== 64'h308 || imm_out !== 64'h0) begin
        n_err++; $display("FAIL hold_%0d got v=%0h mr=%0h rd=%0d pc=%0h exp 1 1 6 308", i, valid_out, mem_read_out, rd_out, pc_out); end
      n_cmp++; if (stall_out !== 1'b1) begin n_err++; $display("FAIL hold_stall_%0d got %0h exp 1", i, stall_out); end
    end
    stall_in = 1'b0;
    cyc();
    n_cmp++; if (valid_out !== 1'b0) begin n_err++; $display("FAIL hold_bubble got %0h exp 0", valid_out); end
    cyc();
    n_cmp++; if (valid_out !== 1'b1 || rs1_out !== 5'd6 || pc_out !== 64'h30C) begin
      n_err++; $display("FAIL hold_add got v=%0h rs1=%0d pc=%0h exp 1 6 30c", valid_out, rs1_out, pc_out); end
  endtask

  task automatic test_back_to_back();
    instr_in = I_SUB; pc_in = 64'h400;
    cyc();
    n_cmp++; if (alu_op_out !== 4'd1 || rd_out !== 5'd3 || rs2_out !== 5'd2) begin
      n_err++; $display("FAIL sub got alu=%0d rd=%0d rs2=%0d exp 1 3 2", alu_op_out, rd_out, rs2_out); end
    instr_in = I_LUI; pc_in = 64'h404;
    cyc();
    n_cmp++; if (alu_op_out !== 4'd10 || imm_out !== 64'hFFFF_FFFF_8000_0000 || rd_out !== 5'd10 || rs1_read_out !== 1'b0) begin
      n_err++; $display("FAIL lui got alu=%0d imm=%0h rd=%0d r1=%0h exp 10 ffffffff80000000 10 0", alu_op_out, imm_out, rd_out, rs1_read_out); end
    instr_in = I_ADDIW; pc_in = 64'h408;
    cyc();
    n_cmp++; if (word_out !== 1'b1 || imm_out !== 64'hFFFF_FFFF_FFFF_FFFF || rd_out !== 5'd4 || alu_op_out !== 4'd0) begin
      n_err++; $display("FAIL addiw got w=%0h imm=%0h rd=%0d alu=%0d exp 1 ffffffffffffffff 4 0", word_out, imm_out, rd_out, alu_op_out); end
    instr_in = I_SD; pc_in = 64'h40C;
    cyc();
    n_cmp++; if (mem_write_out !== 1'b1 || mem_width_out !== 3'd3 || imm_out !== 64'd8 || reg_write_out !== 1'b0 || word_out !== 1'b0) begin
      n_err++; $display("FAIL sd got mw=%0h wd=%0d imm=%0h rw=%0h w=%0h exp 1 3 8 0 0", mem_write_out, mem_width_out, imm_out, reg_write_out, word_out); end
    instr_in = I_NOP; pc_in = 64'h410;
    cyc();
    n_cmp++; if (valid_out !== 1'b1 || reg_write_out !== 1'b0) begin
      n_err++; $display("FAIL nop got v=%0h rw=%0h exp 1 0", valid_out, reg_write_out); end
  endtask

  task automatic test_reset_mid_stall();
    instr_in = I_LD6; pc_in = 64'h500;
    cyc();
    instr_in = I_ADD76; pc_in = 64'h504; reset = 1'b1;
    #1;
    n_cmp++; if (stall_out !== 1'b0) begin n_err++; $display("FAIL rst_stall got %0h exp 0", stall_out); end
    cyc();
    reset = 1'b0;
    n_cmp++; if (valid_out !== 1'b0 || mem_read_out !== 1'b0) begin
      n_err++; $display("FAIL rst_bubble got v=%0h mr=%0h exp 0 0", valid_out, mem_read_out); end
    cyc();
    n_cmp++; if (valid_out !== 1'b1 || rd_out !== 5'd7 || pc_out !== 64'h504) begin
      n_err++; $display("FAIL rst_add got v=%0h rd=%0d pc=%0h exp 1 7 504", valid_out, rd_out, pc_out); end
  endtask

  task automatic test_illegal();
    instr_in = 64'h0000_0001_0000_0013; pc_in = 64'h600;
    cyc();
    n_cmp++; if (valid_out !== 1'b1 || reg_write_out !== 1'b0) begin
      n_err++; $display("FAIL ill_valid got v=%0h rw=%0h exp 1 0", valid_out, reg_write_out); end
`ifdef DECODE_ILLEGAL_TRAP_EN
    n_cmp++; if (illegal_out !== 1'b1 || alu_src_imm_out !== 1'b0) begin
      n_err++; $display("FAIL ill_flag got il=%0h si=%0h exp 1 0", illegal_out, alu_src_imm_out); end
`else
    n_cmp++; if (illegal_out !== 1'b0) begin n_err++; $display("FAIL ill_flag got %0h exp 0", illegal_out); end
`endif
    instr_in = 64'h0000_0000_0000_007F; pc_in = 64'h604;
    cyc();
`ifdef DECODE_ILLEGAL_TRAP_EN
    n_cmp++; if (valid_out !== 1'b1 || illegal_out !== 1'b1 || reg_write_out !== 1'b0) begin
      n_err++; $display("FAIL unsup got v=%0h il=%0h rw=%0h exp 1 1 0", valid_out, illegal_out, reg_write_out); end
`else
    n_cmp++; if (valid_out !== 1'b1 || illegal_out !== 1'b0 || reg_write_out !== 1'b0 || rd_out !== 5'd0) begin
      n_err++; $display("FAIL unsup got v=%0h il=%0h rw=%0h rd=%0d exp 1 0 0 0", valid_out, illegal_out, reg_write_out, rd_out); end
`endif
  endtask

  initial begin
    test_reset();
    test_addi();
    test_load_use();
    test_x0_load();
    test_branch();
    test_flush_stall();
    test_back_to_back();
    test_reset_mid_stall();
    test_illegal();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
